booth_digit_accumulator: RTL

BOOTH_DIGIT_ACCUMULATOR -- requirements
Module: booth_digit_accumulator

---
 rtl/booth_digit_accumulator_pkg.sv | 27 ++
 rtl/booth_digit_accumulator_pp_select.sv | 35 +++
 rtl/booth_digit_accumulator.sv | 103 ++++++++++
 3 files changed

// File: rtl/booth_digit_accumulator_pkg.sv
// Shared encoding for the Booth digit datapath: FSM states, default width
// and the bit positions of the {neg, two, one} digit code.
`timescale 1ns/1ps
package booth_digit_accumulator_pkg;

  localparam int DEF_WIDTH = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int DIG_ONE_BIT = 0;
  localparam int DIG_TWO_BIT = 1;
  localparam int DIG_NEG_BIT = 2;

  typedef logic [2:0] dig_code_t;

  function automatic dig_code_t packDigit(input logic one, input logic two, input logic neg);
    dig_code_t code;
    code              = '0;
    code[DIG_ONE_BIT] = one;
    code[DIG_TWO_BIT] = two;
    code[DIG_NEG_BIT] = neg;
    return code;
  endfunction

endpackage

// File: rtl/booth_digit_accumulator_pp_select.sv
// Booth partial-product selector: picks 0, M or 2M and inverts it for a
// negative digit; the +1 of the two's complement leaves as neg_cin.
`timescale 1ns/1ps
module booth_pp_select
  import booth_digit_accumulator_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] mcand,
  input  logic             one,
  input  logic             two,
  input  logic             neg,
  output logic [WIDTH:0]   pp,
  output logic             neg_cin,
  output logic             invalid
);

  logic [WIDTH:0] w_mult;

  assign invalid = one & two;

  // The invert-plus-carry form keeps -(-2^WIDTH) representable once the
  // carry is added at accumulator width; an invalid code selects zero.
  always_comb begin
    w_mult = '0;
    if (!invalid) begin
      if (one)      w_mult = {mcand[WIDTH-1], mcand};
      else if (two) w_mult = {mcand, 1'b0};
    end
  end

  assign pp      = neg ? ~w_mult : w_mult;
  assign neg_cin = neg;

endmodule

// File: rtl/booth_digit_accumulator.sv
// Accumulates radix-4 Booth digits for one signed multiplicand into a
// 2*WIDTH product; IDLE -> ACC -> DONE with a prod_valid/prod_ready handshake.
`timescale 1ns/1ps
module booth_digit_accumulator
  import booth_digit_accumulator_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   mcand,
  input  logic               dig_valid,
  output logic               dig_ready,
  input  logic               dig_one,
  input  logic               dig_two,
  input  logic               dig_neg,
  input  logic               dig_last,
  output logic [2*WIDTH-1:0] prod,
  output logic               prod_valid,
  input  logic               prod_ready,
  output logic               err
);

  localparam int NDIG = WIDTH / 2;
  localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;

  logic [1:0]         r_state;
  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [IDXW-1:0]    r_idx;
  logic               r_err;

  dig_code_t          w_code;
  logic [WIDTH:0]     w_pp;
  logic               w_negCin;
  logic               w_invalid;
  logic               w_accept;
  logic               w_final;
  logic [2*WIDTH-1:0] w_ppExt;
  logic [2*WIDTH-1:0] w_term;

  assign w_code = packDigit(dig_one, dig_two, dig_neg);

  booth_pp_select #(
    .WIDTH(WIDTH)
  ) u_ppSelect (
    .mcand   (r_mcand),
    .one     (w_code[DIG_ONE_BIT]),
    .two     (w_code[DIG_TWO_BIT]),
    .neg     (w_code[DIG_NEG_BIT]),
    .pp      (w_pp),
    .neg_cin (w_negCin),
    .invalid (w_invalid)
  );

  // Sign-extend, complete the negation with the carry, then weight by 4^idx.
  assign w_ppExt = {{(WIDTH-1){w_pp[WIDTH]}}, w_pp} + {{(2*WIDTH-1){1'b0}}, w_negCin};
  assign w_term  = w_ppExt << {r_idx, 1'b0};

  assign w_accept = dig_valid && (r_state == ST_ACC);
  assign w_final  = dig_last || (r_idx == IDXW'(NDIG - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_mcand <= '0;
      r_acc   <= '0;
      r_idx   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_mcand <= mcand;
            r_acc   <= '0;
            r_idx   <= '0;
            r_err   <= 1'b0;
            r_state <= ST_ACC;
          end
        end
        ST_ACC: begin
          if (w_accept) begin
            r_acc <= r_acc + w_term;
            r_idx <= r_idx + IDXW'(1);
            if (w_invalid) r_err <= 1'b1;
            if (w_final)   r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (prod_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign dig_ready  = (r_state == ST_ACC);
  assign prod_valid = (r_state == ST_DONE);
  assign prod       = r_acc;
  assign err        = r_err;

endmodule
